// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
// Holds the FSM state encoding, datapath/iteration sizing and an
// absolute-value helper used when operands are latched for a signed divide.
package div_pkg;

  localparam int unsigned DIV_W       = 32;
  localparam int unsigned DIV_ITERS   = 32;
  localparam int unsigned DIV_LATENCY = 34;
  localparam int unsigned CNT_W       = $clog2(DIV_ITERS) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Magnitude of v; only negative values in signed mode are negated.
  function automatic logic [DIV_W-1:0] abs_sel(input logic [DIV_W-1:0] v,
                                               input logic is_signed);
    return (is_signed && v[DIV_W-1]) ? DIV_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step (combinational).
// Ports: rem_in   - partial remainder (always < divisor on entry)
//        bit_in   - next dividend bit shifted in
//        divisor  - divisor magnitude
//        rem_c    - updated partial remainder
//        q_bit_c  - quotient bit produced by this step
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_c,
  output logic             q_bit_c
);

  logic [DIV_W-1:0] low;

  // Trial subtract is a full 33-bit compare; the kept difference fits in
  // DIV_W bits because rem_in < divisor, so modular subtraction suffices.
  always_comb begin
    low     = {rem_in[DIV_W-2:0], bit_in};
    q_bit_c = ({rem_in, bit_in} >= {1'b0, divisor});
    rem_c   = q_bit_c ? (low - divisor) : low;
  end

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider.
// Ports: mul_clk   - clock, rising edge
//        reset     - synchronous active-low reset
//        sign      - 1 = signed divide, sampled with start
//        x, y      - dividend / divisor, sampled with start
//        start     - request, accepted only in IDLE
//        cancel    - aborts any operation in progress
//        busy      - operation in flight
//        ready     - one-cycle pulse, quotient/remainder valid
//        quotient  - result, held until the next completed operation
//        remainder - result, held until the next completed operation
module div
  import div_pkg::*;
(
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             sign,
  input  logic [DIV_W-1:0] x,
  input  logic [DIV_W-1:0] y,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic             ready,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  state_t state, state_d;

  logic             accept;
  logic             finish;
  logic             last_iter;

  logic [DIV_W-1:0] x_q;
  logic [DIV_W-1:0] y_q;
  logic             sign_q;
  logic [DIV_W-1:0] dvd;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W-1:0] rem;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic [CNT_W-1:0] cnt;

  logic [DIV_W-1:0] step_rem;
  logic             step_q;
  logic [DIV_W-1:0] q_fix;
  logic [DIV_W-1:0] r_fix;

  // Single step instance, reused every ITER cycle.
  div_step u_step (
    .rem_in  (rem),
    .bit_in  (dvd[DIV_W-1]),
    .divisor (dvs),
    .rem_c   (step_rem),
    .q_bit_c (step_q)
  );

  assign last_iter = (cnt == CNT_W'(DIV_ITERS - 1));

  // State register.
  always_ff @(posedge mul_clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; cancel wins over everything outside DONE.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          state_d = PREP;
          accept  = 1'b1;
        end
      end
      PREP: state_d = cancel ? IDLE : ITER;
      ITER: begin
        if (cancel)         state_d = IDLE;
        else if (last_iter) state_d = FIX;
      end
      FIX: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign fix-up; divide by zero overrides with all-ones / original dividend.
  always_comb begin
    q_fix = q_neg ? DIV_W'(-dvd) : dvd;
    r_fix = r_neg ? DIV_W'(-rem) : rem;
    if (div_zero) begin
      q_fix = '1;
      r_fix = x_q;
    end
  end

  // Registered status outputs.
  always_ff @(posedge mul_clk) begin
    if (!reset) begin
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= finish;
      busy  <= (state_d != IDLE);
    end
  end

  // Datapath: operand capture, magnitude prep, shift/subtract, result write.
  always_ff @(posedge mul_clk) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      sign_q    <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (accept) begin
        x_q    <= x;
        y_q    <= y;
        sign_q <= sign;
      end
      if (state == PREP) begin
        dvd      <= abs_sel(x_q, sign_q);
        dvs      <= abs_sel(y_q, sign_q);
        rem      <= '0;
        q_neg    <= sign_q & (x_q[DIV_W-1] ^ y_q[DIV_W-1]);
        r_neg    <= sign_q & x_q[DIV_W-1];
        div_zero <= (y_q == '0);
        cnt      <= '0;
      end
      if (state == ITER) begin
        // Quotient bits shift into the vacated low end of the dividend.
        rem <= step_rem;
        dvd <= {dvd[DIV_W-2:0], step_q};
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases, randomized operations
// against an arithmetic reference model, cancel, reset and ignored starts.
module tb_div;

  logic        mul_clk = 1'b0;
  logic        reset;
  logic        sign;
  logic [31:0] x;
  logic [31:0] y;
  logic        start;
  logic        cancel;
  logic        busy;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_q = 32'h0;
  logic [31:0] last_r = 32'h0;

  div dut (
    .mul_clk   (mul_clk),
    .reset     (reset),
    .sign      (sign),
    .x         (x),
    .y         (y),
    .start     (start),
    .cancel    (cancel),
    .busy      (busy),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 mul_clk = ~mul_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero when signed.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // One full operation; poke=1 also fires stray starts while busy and in DONE.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [31:0] eq, er;
    int n, pulses;
    model(s, a, b, eq, er);
    @(negedge mul_clk);
    sign = s; x = a; y = b; start = 1'b1;
    @(posedge mul_clk); #1;
    start = 1'b0; x = $urandom; y = $urandom; sign = ~s;
    chk($sformatf("%s busy_after_accept", tag), 32'(busy), 32'd1);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      if (poke && n == 5) start = 1'b1;
      @(posedge mul_clk); #1;
      n++;
      if (poke && n == 6) start = 1'b0;
    end
    chk($sformatf("%s latency", tag), 32'(n), 32'd34);
    chk($sformatf("%s quotient", tag), quotient, eq);
    chk($sformatf("%s remainder", tag), remainder, er);
    if (poke) start = 1'b1;
    @(posedge mul_clk); #1;
    start = 1'b0;
    chk($sformatf("%s ready_drop", tag), 32'(ready), 32'd0);
    chk($sformatf("%s busy_drop", tag), 32'(busy), 32'd0);
    if (poke) begin
      pulses = 0;
      repeat (40) begin
        @(posedge mul_clk); #1;
        if (ready === 1'b1) pulses++;
      end
      chk($sformatf("%s extra_ready", tag), 32'(pulses), 32'd0);
      chk($sformatf("%s held_q", tag), quotient, eq);
    end
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int pulses;
    logic        rs;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; cancel = 1'b0; sign = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge mul_clk);
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    reset = 1'b1;

    run_op("u100_7",     1'b0, 32'd100,         32'd7,           1'b0);
    run_op("s_m7_2",     1'b1, 32'hFFFF_FFF9,   32'd2,           1'b0);
    run_op("u_m7_2",     1'b0, 32'hFFFF_FFF9,   32'd2,           1'b0);
    run_op("s_ovf",      1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   1'b0);
    run_op("u_max_1",    1'b0, 32'hFFFF_FFFF,   32'd1,           1'b0);
    run_op("u_5_0",      1'b0, 32'd5,           32'd0,           1'b0);
    run_op("s_5_0",      1'b1, 32'd5,           32'd0,           1'b0);
    run_op("s_m5_0",     1'b1, 32'hFFFF_FFFB,   32'd0,           1'b0);
    run_op("s_7_m2",     1'b1, 32'd7,           32'hFFFF_FFFE,   1'b0);
    run_op("poke",       1'b0, 32'd1000,        32'd33,          1'b1);

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'($urandom_range(0, 1)) ? 32'hFFFF_FFFF : 32'h0;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rnd%0d", i), rs, ra, rb, 1'b0);
    end

    // start together with cancel in IDLE is refused
    @(negedge mul_clk);
    start = 1'b1; cancel = 1'b1; x = 32'd9; y = 32'd3;
    @(posedge mul_clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel busy", 32'(busy), 32'd0);

    // cancel on the 10th cycle of an operation
    @(negedge mul_clk);
    start = 1'b1; sign = 1'b0; x = 32'd123456; y = 32'd789;
    @(posedge mul_clk); #1;
    start = 1'b0;
    repeat (9) @(posedge mul_clk);
    #1 cancel = 1'b1;
    @(posedge mul_clk); #1;
    cancel = 1'b0;
    chk("cancel busy", 32'(busy), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge mul_clk); #1;
      if (ready === 1'b1) pulses++;
    end
    chk("cancel no_ready", 32'(pulses), 32'd0);
    chk("cancel held_q", quotient, last_q);
    chk("cancel held_r", remainder, last_r);
    run_op("after_cancel", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b0);

    // reset on the 20th cycle of an operation
    @(negedge mul_clk);
    start = 1'b1; sign = 1'b0; x = 32'd999; y = 32'd10;
    @(posedge mul_clk); #1;
    start = 1'b0;
    repeat (19) @(posedge mul_clk);
    #1 reset = 1'b0;
    @(posedge mul_clk); #1;
    chk("midreset ready", 32'(ready), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset quotient", quotient, 32'd0);
    chk("midreset remainder", remainder, 32'd0);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge mul_clk); #1;
      if (ready === 1'b1) pulses++;
    end
    chk("midreset no_ready", 32'(pulses), 32'd0);
    run_op("after_reset", 1'b0, 32'd999, 32'd10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 mul_clk  input  1  clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-low; clock mul_clk.
REQ-003 sign  input  1  1 = signed two's-complement divide, 0 = unsigned; sampled with start.
REQ-004 x  input  32  dividend; sampled with start.
REQ-005 y  input  32  divisor; sampled with start.
REQ-006 start  input  1  request; accepted only in IDLE.
REQ-007 cancel  input  1  pipeline flush; aborts any operation in progress.
REQ-008 busy  output  1  high from the edge after acceptance until ready deasserts or a cancel takes effect.
REQ-009 ready  output reg  1  one-cycle pulse: quotient/remainder are valid.
REQ-010 quotient  output  32  quotient, held until the next completed operation.
REQ-011 remainder  output  32  remainder, held until the next completed operation.

Function
REQ-012 States SHALL be IDLE, PREP, ITER, FIX and DONE, with 3-bit encoding.
REQ-013 Transition IDLE->PREP SHALL occur on an edge where start=1 and cancel=0; x, y and sign are latched on that edge, and later input changes have no effect.
REQ-014 PREP SHALL last 1 cycle: latch |x| and |y| (absolute value only when sign=1), the quotient sign (xs^ys) and the remainder sign (xs), then clear the iteration counter.
REQ-015 ITER SHALL last exactly 32 cycles, each being one restoring step: shift {rem,dividend} left by 1, trial-subtract the divisor (33-bit), keep the difference and set the quotient bit if it is non-negative.
REQ-016 FIX SHALL last 1 cycle: negate the quotient if the quotient sign is 1, negate the remainder if the remainder sign is 1, write the quotient/remainder registers, and set ready<=1.
REQ-017 DONE SHALL last 1 cycle: ready<=0, then return to IDLE; start is ignored in DONE.
REQ-018 Latency: ready SHALL be high in the cycle following the 34th rising edge after the edge that accepted start; there is no back-to-back overlap.
REQ-019 start asserted in any state other than IDLE SHALL be ignored without side effects.
REQ-020 Signed results SHALL truncate toward zero, with the remainder sign equal to the dividend sign and |remainder| < |divisor|.
REQ-021 Divide by zero SHALL give quotient=32'hFFFFFFFF and remainder=x (the original value), in both modes, with the same latency.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000 and remainder=0 with no exception.
REQ-023 cancel=1 in PREP, ITER or FIX SHALL return the block to IDLE on that edge, with no ready pulse and quotient/remainder unchanged.
REQ-024 start and cancel asserted together in IDLE: cancel SHALL win, and the request is not accepted.

Reset
REQ-025 reset=0 SHALL force the following on the next edge, including mid-operation: state=IDLE, ready=0, busy=0, quotient=0, remainder=0, counter=0.
REQ-026 An operation interrupted by reset SHALL never produce a ready pulse.

Structure
REQ-027 A shared package SHALL hold: the state encoding, DIV_W=32, DIV_ITERS=32 and DIV_LATENCY=34.
REQ-028 One combinational sub-module div_step SHALL implement a single restoring shift/subtract step (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit); ITER instantiates it once and reuses it every cycle.

Verification
REQ-029 Unsigned x=100, y=7 -> ready exactly 34 edges after start; quotient=14, remainder=2.
REQ-030 Signed x=-7 (0xFFFFFFF9), y=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; the same inputs unsigned -> quotient=0x7FFFFFFC, remainder=1.
REQ-031 Signed x=0x80000000, y=0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned x=0xFFFFFFFF, y=1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-032 x=5, y=0 (both modes) and signed x=-5, y=0 -> quotient=0xFFFFFFFF, remainder=x, with normal latency.
REQ-033 Start, then cancel on the 10th cycle -> busy low on the next cycle, no ready within 40 cycles, previous quotient/remainder retained; a new start afterwards completes correctly.
REQ-034 Start, then reset=0 on the 20th cycle -> all outputs 0 and state IDLE; a second start asserted while busy is ignored, and only one ready pulse occurs.
